// File: rtl/crc_sequencer_if.sv
// Byte-stream input and result output handshakes between a producer/consumer and crc_sequencer.
interface crc_sequencer_if #(
    parameter int unsigned MAX_BITS = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [MAX_BITS-1:0] result;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/crc_sequencer.sv
// Byte-stream controller for one crcN datapath: init pulse, eight shifts per byte,
// then capture of the final CRC behind a valid/ready result handshake.
module crc_sequencer #(
    parameter int unsigned MAX_BITS = 32,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                flush,
    crc_sequencer_if.slave      bus,
    output logic                crc_init,
    output logic                crc_shift,
    output logic [2:0]          crc_bit_index,
    output logic [7:0]          crc_data,
    input  logic [MAX_BITS-1:0] crc_in,
    output logic [COUNT_W-1:0]  byte_count,
    output logic                busy
);
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        WAIT_BYTE = 3'd2,
        SHIFT     = 3'd3,
        FINISH    = 3'd4,
        DONE      = 3'd5
    } state_e;

    state_e              state, state_d;
    logic                last_q, last_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                init_d, shift_d, busy_d;
    logic [IDX_W-1:0]    idx_d;
    logic [7:0]          data_d;
    logic [COUNT_W-1:0]  count_d;
    logic [MAX_BITS-1:0] result_q, result_d;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // State and registered outputs; the bit counter doubles as crc_bit_index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            crc_init      <= 1'b0;
            crc_shift     <= 1'b0;
            crc_bit_index <= '0;
            crc_data      <= '0;
            result_q      <= '0;
            byte_count    <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            last_q        <= last_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            crc_init      <= init_d;
            crc_shift     <= shift_d;
            crc_bit_index <= idx_d;
            crc_data      <= data_d;
            result_q      <= result_d;
            byte_count    <= count_d;
            busy          <= busy_d;
        end
    end

    // Next state, datapath updates and next-cycle output values.
    always_comb begin
        state_d  = state;
        last_d   = last_q;
        idx_d    = '0;
        data_d   = crc_data;
        count_d  = byte_count;
        result_d = result_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    state_d = INIT;
                end
            end
            INIT: state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    last_d  = bus.in_last;
                    count_d = byte_count + COUNT_W'(1);
                    state_d = SHIFT;
                end else if (flush) begin
                    state_d = FINISH;
                end
            end
            SHIFT: begin
                if (crc_bit_index == LAST_IDX) begin
                    state_d = last_q ? FINISH : WAIT_BYTE;
                end else begin
                    idx_d = crc_bit_index + IDX_W'(1);
                end
            end
            FINISH: begin
                result_d = crc_in;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort discards the step in progress but keeps result and count.
        if (abort) begin
            state_d  = IDLE;
            last_d   = last_q;
            idx_d    = '0;
            data_d   = crc_data;
            count_d  = byte_count;
            result_d = result_q;
        end

        in_ready_d  = (state_d == WAIT_BYTE);
        init_d      = (state_d == INIT);
        shift_d     = (state_d == SHIFT);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end
endmodule
